io_input_queue: RTL and testbench
=================================

Name: io_input_queue

Overview:
- Upstream feeder for the DMA input path: takes the raw board apply push-button and the 22-bit switch word, and debounces the button.
- On each confirmed press, captures the switch word into a 32-entry FIFO.
- Exposes the head word, the occupancy count and a pop strobe to the DMA.
- Replaces the DMA's button-edge-clocked queue writes with a single-clock, debounced, synchronous queue.

Parameters:
- DATA_W, 22: width of one captured input word.
- DEPTH, 32: FIFO entries; must be a power of 2.
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronized cycles required to accept a button level change.
- CNT_W, 16: width of avail_count.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- apply_btn  in  1  raw push-button, active-low (0 = pressed), asynchronous to clock.
- io_in  in  DATA_W  raw switch word, asynchronous to clock.
- pop  in  1  single-cycle read strobe from DMA (RI/RAI/PAUSE consumption).
- head_data  out  DATA_W  word at read pointer; 0 when empty.
- avail_count  out  CNT_W  number of unread entries, 0..DEPTH.
- empty  out  1  avail_count == 0.
- full  out  1  avail_count == DEPTH.
- overflow  out  1  sticky flag; a push was lost (or an entry overwritten, with the optional feature).
- clear_overflow  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync-released use):
  - wr_ptr = rd_ptr = 0, count = 0, overflow = 0, debounce FSM in RELEASED, debounce counter = 0.
  - Synchronizer flops are set to "released" (1) for the button and 0 for io_in.
  - Output values in reset: head_data = 0, avail_count = 0, empty = 1, full = 0.
- Synchronization: apply_btn and io_in each pass through 2 flip-flop stages. Only the synchronized versions are used downstream.
- Debounce FSM (states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT):
  - RELEASED: on sync_btn == 0, go to PRESS_WAIT and clear the counter.
  - PRESS_WAIT: while sync_btn == 0, increment the counter. When the counter reaches DEBOUNCE_CYCLES-1, go to PRESSED and assert push for exactly one cycle. If sync_btn == 1 at any point, return to RELEASED.
  - PRESSED: on sync_btn == 1, go to RELEASE_WAIT and clear the counter.
  - RELEASE_WAIT: while sync_btn == 1, increment the counter. When the counter reaches DEBOUNCE_CYCLES-1, go to RELEASED. If sync_btn == 0, return to PRESSED (no new push).
  - Exactly one push per physical press, regardless of hold time.
- Capture: the push writes the synchronized io_in value sampled in the same cycle push is asserted.
- FIFO write: on push && !full, mem[wr_ptr] <= word, wr_ptr++ (wraps mod DEPTH), count++.
- FIFO read: on pop && !empty, rd_ptr++ (wraps mod DEPTH), count--.
- Simultaneous push and pop:
  - Not empty and not full: both occur, count unchanged.
  - Empty: pop ignored, push occurs, count becomes 1.
  - Full: both occur, count stays DEPTH, no overflow.
- Push while full without pop: word dropped, overflow <= 1, pointers unchanged.
- Pop while empty: ignored; no flag.
- clear_overflow: clears overflow the next cycle. If it coincides with a new overflow event, the set wins.
- Latency:
  - Pushed word is visible on head_data and in avail_count the cycle after the push cycle.
  - Total latency from apply_btn going low to visibility is DEBOUNCE_CYCLES + 3 cycles, with no bounce.
- Output timing: head_data is combinational from mem[rd_ptr], gated to 0 when empty. avail_count, empty and full are derived from the registered count.
- Reset mid-press: FSM returns to RELEASED. If the button is still held after reset release, the press is debounced and captured as a new push.

Optional Feature:
- Macro: IOQ_DROP_OLDEST_EN.
- Defined: a push while full without pop overwrites the oldest entry. The word is written at wr_ptr, and wr_ptr and rd_ptr both advance. count stays DEPTH and overflow is set. head_data then shows the next-oldest entry.
- Undefined: the newest word is dropped, as described in Behaviour.

Decomposition:
- Package io_queue_pkg holds:
  - Debounce state enum {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT}.
  - Constants IOQ_DATA_W = 22 and IOQ_DEPTH = 32.
  - A function computing pointer width from DEPTH.
- Sub-module btn_debouncer, containing the 2-FF synchronizer, the counter and the FSM, with a one-cycle press_pulse output. The FIFO and capture logic stay in io_input_queue.

Test Plan (DEBOUNCE_CYCLES = 4):
- Clean press: io_in = 22'h0000A5, apply_btn held low for 20 cycles -> exactly one push; 7 cycles after the falling edge head_data = 22'h0000A5, avail_count = 1, empty = 0.
- Bounce rejection: apply_btn toggles low/high every 2 cycles for 16 cycles, then held low -> exactly one push, after the stable period only.
- Fill and overflow: 33 clean presses with io_in = 1..33 -> avail_count = 32, full = 1, overflow = 1, head_data = 1. With IOQ_DROP_OLDEST_EN defined: head_data = 2.
- Wrap-around: 40 presses interleaved with pops after each -> head_data tracks the latest word, count never exceeds 1, and pointers wrap past 31 correctly.
- Simultaneous events: push and pop in the same cycle at count 0, 5 and 32 -> resulting count 1, 5 and 32; overflow stays 0.
- Async reset while in PRESS_WAIT with 3 entries queued -> count = 0, empty = 1, head_data = 0; after release, a still-held button yields one push.

Source files
------------

// File: rtl/io_queue_pkg.sv
// io_queue_pkg: shared types and constants for the debounced input queue.
`default_nettype none

package io_queue_pkg;

    localparam int unsigned IOQ_DATA_W = 22;
    localparam int unsigned IOQ_DEPTH  = 32;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    function automatic int unsigned ioq_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/io_input_queue_btn_debouncer.sv
// btn_debouncer: 2-FF synchronizer plus stable-level FSM for an active-low push-button,
// emitting one registered pulse per accepted press.
`default_nettype none

module btn_debouncer
    import io_queue_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n_i,
    output logic press_pulse_o
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The accepting edge is the one on which the counter would reach DEBOUNCE_CYCLES-1.
    localparam logic [DB_W-1:0] PRE_LAST = DB_W'((DEBOUNCE_CYCLES > 1) ? (DEBOUNCE_CYCLES - 2) : 0);

    logic            sync1_q;
    logic            sync2_q;
    db_state_e       state_q;
    logic [DB_W-1:0] cnt_q;
    logic            press_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RELEASED;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (!sync2_q) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (sync2_q) begin
                        state_q <= RELEASED;
                    end else if (cnt_q == PRE_LAST) begin
                        state_q <= PRESSED;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (sync2_q) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!sync2_q) begin
                        state_q <= PRESSED;
                    end else if (cnt_q == PRE_LAST) begin
                        state_q <= RELEASED;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RELEASED;
            endcase
        end
    end

    assign press_pulse_o = press_q;

endmodule

`default_nettype wire

// File: rtl/io_input_queue.sv
// io_input_queue: debounced apply button captures the synchronized switch word into a FIFO.
// Optional IOQ_DROP_OLDEST_EN: a push into a full queue overwrites the oldest entry.
`default_nettype none

module io_input_queue
    import io_queue_pkg::*;
#(
    parameter int unsigned DATA_W          = IOQ_DATA_W,
    parameter int unsigned DEPTH           = IOQ_DEPTH,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              apply_btn,
    input  logic [DATA_W-1:0] io_in,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  avail_count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    input  logic              clear_overflow
);

    localparam int unsigned PTR_W = ioq_ptr_w(DEPTH);

    logic [DATA_W-1:0] io_s1_q;
    logic [DATA_W-1:0] io_s2_q;
    logic              push;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              overflow_q, overflow_d;

    logic              wr_en;
    logic              rd_adv;
    logic              ovf_set;

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock        (clock),
        .reset        (reset),
        .btn_n_i      (apply_btn),
        .press_pulse_o(push)
    );

    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W+1)'(DEPTH));

    // A full queue with a coincident pop always has room for the push.
    assign ovf_set = push && full && !pop;
`ifdef IOQ_DROP_OLDEST_EN
    assign wr_en  = push;
    assign rd_adv = (pop && !empty) || ovf_set;
`else
    assign wr_en  = push && (!full || pop);
    assign rd_adv = pop && !empty;
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_adv) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en && !rd_adv) begin
            count_d = count_q + 1'b1;
        end else if (!wr_en && rd_adv) begin
            count_d = count_q - 1'b1;
        end
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_s1_q    <= '0;
            io_s2_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            io_s1_q    <= io_in;
            io_s2_q    <= io_s1_q;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= io_s2_q;
        end
    end

    assign head_data   = empty ? '0 : mem_q[rd_ptr_q];
    assign avail_count = CNT_W'(count_q);
    assign overflow    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_io_input_queue.sv
// tb_io_input_queue: scoreboard bench for io_input_queue with DEBOUNCE_CYCLES = 4.
`default_nettype none
`timescale 1ns/1ps

module tb_io_input_queue;

    localparam int DW    = 22;
    localparam int DEPTH = 32;
    localparam int DB    = 4;
    localparam int CW    = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          apply_btn = 1'b1;
    logic [DW-1:0] io_in = '0;
    logic          pop = 1'b0;
    logic          clear_overflow = 1'b0;
    logic [DW-1:0] head_data;
    logic [CW-1:0] avail_count;
    logic          empty;
    logic          full;
    logic          overflow;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb[$];
    logic          model_ovf = 1'b0;

    io_input_queue #(
        .DATA_W(DW), .DEPTH(DEPTH), .DEBOUNCE_CYCLES(DB), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset), .apply_btn(apply_btn), .io_in(io_in),
        .pop(pop), .head_data(head_data), .avail_count(avail_count),
        .empty(empty), .full(full), .overflow(overflow),
        .clear_overflow(clear_overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic model_push(input logic [DW-1:0] w);
        if (sb.size() < DEPTH) begin
            sb.push_back(w);
        end else begin
            model_ovf = 1'b1;
`ifdef IOQ_DROP_OLDEST_EN
            void'(sb.pop_front());
            sb.push_back(w);
`endif
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(avail_count), 32'(sb.size()));
        check({tag, "_empty"}, 32'(empty), 32'(sb.size() == 0));
        check({tag, "_full"},  32'(full),  32'(sb.size() == DEPTH));
        check({tag, "_head"},  32'(head_data), (sb.size() == 0) ? 32'd0 : 32'(sb[0]));
        check({tag, "_ovf"},   32'(overflow), 32'(model_ovf));
    endtask

    task automatic press(input logic [DW-1:0] w);
        io_in = w;
        apply_btn = 1'b0;
        step(8);
        apply_btn = 1'b1;
        step(8);
        model_push(w);
    endtask

    task automatic pop_check(input string tag);
        check(tag, 32'(head_data), (sb.size() == 0) ? 32'd0 : 32'(sb[0]));
        pop = 1'b1;
        step(1);
        pop = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
    endtask

    // Push lands on the 7th edge after the button falls; hold pop across that edge.
    task automatic push_with_pop(input logic [DW-1:0] w, input string tag);
        io_in = w;
        apply_btn = 1'b0;
        step(6);
        check({tag, "_head_before"}, 32'(head_data), (sb.size() == 0) ? 32'd0 : 32'(sb[0]));
        pop = 1'b1;
        step(1);
        pop = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
        sb.push_back(w);
        apply_btn = 1'b1;
        step(8);
        check_state(tag);
    endtask

    initial begin
        step(3);
        check_state("reset");
        reset = 1'b0;
        step(2);

        // Clean press with exact visibility latency
        io_in = 22'h0000A5;
        apply_btn = 1'b0;
        step(6);
        check("clean_not_yet", 32'(empty), 32'd1);
        step(1);
        check("clean_head", 32'(head_data), 32'h0000A5);
        check("clean_count", 32'(avail_count), 32'd1);
        check("clean_empty", 32'(empty), 32'd0);
        step(13);
        apply_btn = 1'b1;
        step(8);
        sb.push_back(22'h0000A5);
        check_state("clean_once");
        pop_check("clean_pop");

        // Bounce rejection
        io_in = 22'h001234;
        for (int i = 0; i < 4; i++) begin
            apply_btn = 1'b0;
            step(2);
            apply_btn = 1'b1;
            step(2);
        end
        check("bounce_none", 32'(avail_count), 32'd0);
        apply_btn = 1'b0;
        step(8);
        apply_btn = 1'b1;
        step(8);
        sb.push_back(22'h001234);
        check_state("bounce_one");
        pop_check("bounce_pop");

        // Fill and overflow
        for (int i = 1; i <= 33; i++) press(DW'(i));
        check_state("fill");
`ifdef IOQ_DROP_OLDEST_EN
        check("fill_head_const", 32'(head_data), 32'd2);
`else
        check("fill_head_const", 32'(head_data), 32'd1);
`endif
        clear_overflow = 1'b1;
        step(1);
        clear_overflow = 1'b0;
        model_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Simultaneous push and pop at 32, 5 and 0
        push_with_pop(22'h2AAAAA, "sim32");
        while (sb.size() > 5) pop_check("drain5");
        push_with_pop(22'h155555, "sim5");
        while (sb.size() > 0) pop_check("drain0");
        push_with_pop(22'h0ABCDE, "sim0");
        pop_check("sim0_pop");

        // Wrap-around with interleaved pops
        for (int i = 0; i < 40; i++) begin
            press(DW'(i + 100));
            check("wrap_count1", 32'(avail_count), 32'd1);
            pop_check("wrap_head");
            check("wrap_count0", 32'(avail_count), 32'd0);
        end

        // Async reset while debouncing, with entries queued
        for (int i = 0; i < 3; i++) press(DW'(i + 7));
        check("pre_reset_count", 32'(avail_count), 32'd3);
        io_in = 22'h0003AB;
        apply_btn = 1'b0;
        step(4);
        #2 reset = 1'b1;
        #1;
        sb.delete();
        model_ovf = 1'b0;
        check_state("in_reset");
        step(1);
        reset = 1'b0;
        step(10);
        sb.push_back(22'h0003AB);
        check_state("after_reset_push");
        step(10);
        check("after_reset_once", 32'(avail_count), 32'd1);
        apply_btn = 1'b1;
        step(8);
        pop_check("after_reset_pop");
        check_state("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
